// File: rtl/lamp_fpu_sqrt_iter.sv
// Iterative restoring square root for unpacked lampFPU operands.
// Produces BPC root bits per cycle, then rounds and resolves special operands.
module lamp_fpu_sqrt_iter #(
   parameter int E_DW = 8,
   parameter int F_DW = 7,
   parameter int BPC  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            doSqrt_i,
   input  logic [1:0]      rndMode_i,
   input  logic            signum_op_i,
   input  logic [E_DW-1:0] extExp_op_i,
   input  logic [F_DW:0]   extMant_op_i,
   input  logic            isZero_op_i,
   input  logic            isInf_op_i,
   input  logic            isSNAN_op_i,
   input  logic            isQNAN_op_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic            s_res_o,
   output logic [E_DW-1:0] e_res_o,
   output logic [F_DW-1:0] f_res_o,
   output logic            isInvalid_o,
   output logic            isInexact_o
);
   localparam int ITERS = (F_DW + 2 + BPC - 1) / BPC;
   localparam int RB    = ITERS * BPC;        // root bits actually produced
   localparam int RW    = RB + 3;             // partial remainder width
   localparam int XW    = 2 * RB;             // radicand aligned to root precision
   localparam int SH    = XW - (F_DW + 2);
   localparam int EXB   = RB - (F_DW + 2);    // root bits below guard, folded into sticky
   localparam int EXW   = E_DW + 2;
   localparam int CW    = $clog2(ITERS + 1);
   localparam logic [EXW-1:0] BIAS  = EXW'((1 << (E_DW - 1)) - 1);
   localparam logic [RB-1:0]  XMASK = RB'((1 << EXB) - 1);
   localparam logic [F_DW-1:0] QNAN_F = {1'b1, {(F_DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PREP, CALC, ROUND} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      rnd_q;
   logic            sgn_q, zero_q, inf_q, snan_q, qnan_q;
   logic [E_DW-1:0] exp_q, e_q;
   logic [F_DW:0]   mant_q;
   logic [XW-1:0]   x_q, x_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [RB-1:0]   root_q, root_d;
   logic            spc_q, spc_s_q, spc_inv_q;
   logic [E_DW-1:0] spc_e_q;
   logic [F_DW-1:0] spc_f_q;
   logic            busy_q, valid_q, s_q, inv_q, inx_q;
   logic [E_DW-1:0] eo_q;
   logic [F_DW-1:0] fo_q;

   // PREP: exponent halving and radicand alignment
   logic signed [EXW-1:0] e_unb, e_adj;
   logic [F_DW+1:0]       rad;
   logic [E_DW-1:0]       e_res_d;
   logic [XW-1:0]         x_init;
   logic                  spc_d, spc_s_d, spc_inv_d;
   logic [E_DW-1:0]       spc_e_d;
   logic [F_DW-1:0]       spc_f_d;

   always_comb begin
      e_unb   = $signed({2'b00, exp_q}) - $signed(BIAS);
      rad     = e_unb[0] ? {mant_q, 1'b0} : {1'b0, mant_q};
      e_adj   = e_unb[0] ? e_unb - EXW'(1) : e_unb;
      e_res_d = E_DW'((e_adj >>> 1) + $signed(BIAS));
      x_init  = XW'(rad) << SH;
      spc_d     = 1'b1;
      spc_s_d   = 1'b0;
      spc_e_d   = '1;
      spc_f_d   = QNAN_F;
      spc_inv_d = 1'b0;
      if (snan_q)      spc_inv_d = 1'b1;
      else if (qnan_q) spc_inv_d = 1'b0;
      else if (zero_q) begin
         spc_s_d = sgn_q;
         spc_e_d = '0;
         spc_f_d = '0;
      end
      else if (sgn_q)  spc_inv_d = 1'b1;
      else if (inf_q)  spc_f_d = '0;
      else             spc_d = 1'b0;
   end

   // CALC: BPC restoring steps per cycle
   logic [RW-1:0] trial;
   always_comb begin
      x_d    = x_q;
      rem_d  = rem_q;
      root_d = root_q;
      trial  = '0;
      for (int b = 0; b < BPC; b++) begin
         rem_d = {rem_d[RW-3:0], x_d[XW-1 -: 2]};
         trial = RW'({root_d, 2'b01});
         if (rem_d >= trial) begin
            rem_d  = rem_d - trial;
            root_d = {root_d[RB-2:0], 1'b1};
         end else begin
            root_d = {root_d[RB-2:0], 1'b0};
         end
         x_d = {x_d[XW-3:0], 2'b00};
      end
   end

   // ROUND: result is positive, so RDN collapses onto RTZ
   logic [F_DW:0]   mant_r;
   logic            guard, sticky, lsb, inc, carry;
   logic [F_DW-1:0] f_rnd;
   always_comb begin
      mant_r = root_q[RB-1 -: F_DW+1];
      guard  = root_q[EXB];
      sticky = (|rem_q) | (|(root_q & XMASK));
      lsb    = mant_r[0];
      case (rnd_q)
         2'b00:   inc = guard & (sticky | lsb);
         2'b11:   inc = guard | sticky;
         default: inc = 1'b0;
      endcase
      carry = inc & (&mant_r);
      f_rnd = mant_r[F_DW-1:0] + F_DW'(inc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0; rnd_q <= '0;
         sgn_q <= 1'b0; zero_q <= 1'b0; inf_q <= 1'b0; snan_q <= 1'b0; qnan_q <= 1'b0;
         exp_q <= '0; e_q <= '0; mant_q <= '0;
         x_q <= '0; rem_q <= '0; root_q <= '0;
         spc_q <= 1'b0; spc_s_q <= 1'b0; spc_inv_q <= 1'b0; spc_e_q <= '0; spc_f_q <= '0;
         busy_q <= 1'b0; valid_q <= 1'b0; s_q <= 1'b0; inv_q <= 1'b0; inx_q <= 1'b0;
         eo_q <= '0; fo_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: if (doSqrt_i) begin
               rnd_q  <= rndMode_i;
               sgn_q  <= signum_op_i;
               exp_q  <= extExp_op_i;
               mant_q <= extMant_op_i;
               zero_q <= isZero_op_i;
               inf_q  <= isInf_op_i;
               snan_q <= isSNAN_op_i;
               qnan_q <= isQNAN_op_i;
               busy_q <= 1'b1;
               state_q <= PREP;
            end
            PREP: begin
               spc_q <= spc_d; spc_s_q <= spc_s_d; spc_inv_q <= spc_inv_d;
               spc_e_q <= spc_e_d; spc_f_q <= spc_f_d;
               e_q    <= e_res_d;
               x_q    <= x_init;
               rem_q  <= '0;
               root_q <= '0;
               cnt_q  <= '0;
               state_q <= CALC;
            end
            CALC: begin
               x_q    <= x_d;
               rem_q  <= rem_d;
               root_q <= root_d;
               if (cnt_q == CW'(ITERS - 1)) state_q <= ROUND;
               else                         cnt_q <= cnt_q + CW'(1);
            end
            ROUND: begin
               if (spc_q) begin
                  s_q <= spc_s_q; eo_q <= spc_e_q; fo_q <= spc_f_q;
                  inv_q <= spc_inv_q; inx_q <= 1'b0;
               end else begin
                  s_q <= 1'b0; eo_q <= e_q + E_DW'(carry); fo_q <= f_rnd;
                  inv_q <= 1'b0; inx_q <= guard | sticky;
               end
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign valid_o     = valid_q;
   assign s_res_o     = s_q;
   assign e_res_o     = eo_q;
   assign f_res_o     = fo_q;
   assign isInvalid_o = inv_q;
   assign isInexact_o = inx_q;
endmodule

// File: tb/tb_lamp_fpu_sqrt_iter.sv
// Bench for lamp_fpu_sqrt_iter: BPC=1/2/4 instances driven in parallel and
// compared against an integer-isqrt reference model.
module tb_lamp_fpu_sqrt_iter;
   logic       clk = 1'b0;
   logic       rst, doSqrt;
   logic [1:0] rnd;
   logic       sg, z, inf, sn, qn;
   logic [7:0] ex, mt;
   logic       busy[3], valid[3], s[3], inv[3], inx[3];
   logic [7:0] e[3];
   logic [6:0] f[3];
   int         n_chk = 0, n_fail = 0;
   int         LAT[3] = '{11, 7, 5};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      lamp_fpu_sqrt_iter #(.E_DW(8), .F_DW(7), .BPC(1 << g)) u_dut (
         .clk(clk), .rst(rst), .doSqrt_i(doSqrt), .rndMode_i(rnd),
         .signum_op_i(sg), .extExp_op_i(ex), .extMant_op_i(mt),
         .isZero_op_i(z), .isInf_op_i(inf), .isSNAN_op_i(sn), .isQNAN_op_i(qn),
         .busy_o(busy[g]), .valid_o(valid[g]), .s_res_o(s[g]), .e_res_o(e[g]),
         .f_res_o(f[g]), .isInvalid_o(inv[g]), .isInexact_o(inx[g]));
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: root = isqrt(radicand * 2^16) read as 1.fffffff g, rounded by mode
   function automatic void model(input logic ps, input logic [7:0] pe, input logic [7:0] pm,
                                 input logic pz, input logic pi, input logic psn, input logic pqn,
                                 input logic [1:0] rm, output logic es, output logic [7:0] ee,
                                 output logic [6:0] ef, output logic einv, output logic einx);
      int     ue;
      longint rd, r, x, mant;
      logic   g, st, up;
      es = 1'b0; ee = 8'hFF; ef = 7'h40; einv = 1'b0; einx = 1'b0;
      if (psn)      einv = 1'b1;
      else if (pqn) einv = 1'b0;
      else if (pz)  begin es = ps; ee = 8'h00; ef = 7'h00; end
      else if (ps)  einv = 1'b1;
      else if (pi)  ef = 7'h00;
      else begin
         ue = int'(pe) - 127;
         rd = longint'(pm);
         if (ue % 2 != 0) begin rd = rd * 2; ue = ue - 1; end
         x = rd * 512;
         r = 0;
         while ((r + 1) * (r + 1) <= x) r++;
         g    = r[0];
         st   = (r * r != x);
         mant = r / 2;
         case (rm)
            2'd0:    up = g && (st || mant[0]);
            2'd3:    up = g || st;
            default: up = 1'b0;
         endcase
         mant = mant + longint'(up);
         ue   = ue / 2 + 127;
         if (mant == 256) begin mant = 128; ue = ue + 1; end
         ee   = 8'(ue);
         ef   = mant[6:0];
         einx = g || st;
      end
   endfunction

   task automatic set_op(input logic ps, input logic [7:0] pe, input logic [7:0] pm,
                         input logic pz, input logic pi, input logic psn, input logic pqn,
                         input logic [1:0] rm);
      sg = ps; ex = pe; mt = pm; z = pz; inf = pi; sn = psn; qn = pqn; rnd = rm;
   endtask

   task automatic run_op(input string tag, input logic ps, input logic [7:0] pe,
                         input logic [7:0] pm, input logic pz, input logic pi,
                         input logic psn, input logic pqn, input logic [1:0] rm);
      logic       es, einv, einx;
      logic [7:0] ee;
      logic [6:0] ef;
      int         got[3] = '{-1, -1, -1};
      logic       cs[3], cinv[3], cinx[3], cbusy[3];
      logic [7:0] ce[3];
      logic [6:0] cf[3];
      model(ps, pe, pm, pz, pi, psn, pqn, rm, es, ee, ef, einv, einx);
      @(negedge clk);
      set_op(ps, pe, pm, pz, pi, psn, pqn, rm);
      doSqrt = 1'b1;
      @(posedge clk); #1;
      doSqrt = 1'b0;
      for (int g = 0; g < 3; g++) chk($sformatf("%s busy_rise[%0d]", tag, g), 32'(busy[g]), 32'd1);
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 3; g++)
            if (valid[g] && got[g] < 0) begin
               got[g] = k; cs[g] = s[g]; ce[g] = e[g]; cf[g] = f[g];
               cinv[g] = inv[g]; cinx[g] = inx[g]; cbusy[g] = busy[g];
            end
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s latency[%0d]", tag, g), 32'(got[g]), 32'(LAT[g]));
         if (got[g] >= 0) begin
            chk($sformatf("%s s[%0d]", tag, g),    32'(cs[g]),    32'(es));
            chk($sformatf("%s e[%0d]", tag, g),    32'(ce[g]),    32'(ee));
            chk($sformatf("%s f[%0d]", tag, g),    32'(cf[g]),    32'(ef));
            chk($sformatf("%s inv[%0d]", tag, g),  32'(cinv[g]),  32'(einv));
            chk($sformatf("%s inx[%0d]", tag, g),  32'(cinx[g]),  32'(einx));
            chk($sformatf("%s busy_fall[%0d]", tag, g), 32'(cbusy[g]), 32'd0);
            chk($sformatf("%s f_hold[%0d]", tag, g), 32'(f[g]), 32'(ef));
         end
      end
   endtask

   initial begin
      int vk;
      rst = 1'b1; doSqrt = 1'b0;
      set_op(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int g = 0; g < 3; g++)
         chk($sformatf("reset outs[%0d]", g),
             32'({busy[g], valid[g], s[g], e[g], f[g], inv[g], inx[g]}), 32'd0);

      // Directed cases
      run_op("sqrt4",   1'b0, 8'd129, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      run_op("sqrt2",   1'b0, 8'd128, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      for (int m = 0; m < 4; m++)
         run_op($sformatf("sqrt3_rm%0d", m), 1'b0, 8'd128, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(m));
      run_op("neg1",    1'b1, 8'd127, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      run_op("snan",    1'b0, 8'hFF, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      run_op("qnan",    1'b1, 8'hFF, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      run_op("negzero", 1'b1, 8'd0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      run_op("posinf",  1'b0, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      run_op("neginf",  1'b1, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      run_op("snan_qn_z", 1'b1, 8'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
      run_op("round_carry", 1'b0, 8'd128, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

      // doSqrt held high: operand change mid-op is ignored, second op starts in valid cycle
      @(negedge clk);
      set_op(1'b0, 8'd129, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      doSqrt = 1'b1;
      @(posedge clk); #1;
      set_op(1'b0, 8'd128, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      vk = -1;
      for (int k = 1; k <= 23; k++) begin
         @(posedge clk); #1;
         if (valid[0] && k <= 11 && vk < 0) vk = k;
         if (k == 11) begin
            chk("b2b first e", 32'(e[0]), 32'd128);
            chk("b2b first f", 32'(f[0]), 32'd0);
         end
         if (k == 12) begin
            doSqrt = 1'b0;
            chk("b2b restart busy", 32'(busy[0]), 32'd1);
         end
         if (k == 23) begin
            chk("b2b second valid", 32'(valid[0]), 32'd1);
            chk("b2b second e", 32'(e[0]), 32'd127);
            chk("b2b second f", 32'(f[0]), 32'h35);
         end
      end
      chk("b2b first latency", 32'(vk), 32'd11);
      repeat (16) @(posedge clk);

      // Reset mid-CALC aborts without a valid pulse
      @(negedge clk);
      set_op(1'b0, 8'd129, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      doSqrt = 1'b1;
      @(posedge clk); #1;
      doSqrt = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int g = 0; g < 3; g++)
         chk($sformatf("midrst outs[%0d]", g),
             32'({busy[g], valid[g], s[g], e[g], f[g], inv[g], inx[g]}), 32'd0);
      vk = 0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 3; g++) if (valid[g]) vk++;
      end
      chk("midrst no valid", 32'(vk), 32'd0);
      run_op("post_rst_sqrt4", 1'b0, 8'd129, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Randomized operands, modes and occasional class flags
      for (int i = 0; i < 50; i++) begin
         logic rz, ri, rs, rq, rsg;
         rsg = ($urandom_range(0, 7) == 0);
         rz  = ($urandom_range(0, 15) == 0);
         ri  = ($urandom_range(0, 15) == 0);
         rs  = ($urandom_range(0, 19) == 0);
         rq  = ($urandom_range(0, 19) == 0);
         run_op($sformatf("rand%0d", i), rsg, 8'($urandom_range(1, 254)),
                {1'b1, 7'($urandom)}, rz, ri, rs, rq, 2'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
